// File: rtl/riscv_defs.sv
// Shared RV32I decode definitions: opcodes, immediate formats, NOP.
package riscv_defs;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'h03,
        OPC_OP_IMM = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_STORE  = 7'h23,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37,
        OPC_BRANCH = 7'h63,
        OPC_JALR   = 7'h67,
        OPC_JAL    = 7'h6F
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/idecode_if.sv
// Fetch/EX facing signal bundle of the decode stage.
interface idecode_if #(
    parameter int NB_WORD = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_REG  = 5
);
    logic [NB_WORD-1:0] i_instruction;
    logic [NB_ADDR-1:0] i_pc;
    logic               i_flush;
    logic               i_ex_mem_read;
    logic [NB_REG-1:0]  i_ex_rd;
    logic               o_hazard_detected;
    logic               o_valid;
    logic [NB_ADDR-1:0] o_pc;
    logic [NB_REG-1:0]  o_rs1;
    logic [NB_REG-1:0]  o_rs2;
    logic [NB_REG-1:0]  o_rd;
    logic [2:0]         o_funct3;
    logic               o_funct7b5;
    logic [NB_WORD-1:0] o_imm;
    logic               o_reg_write;
    logic               o_mem_read;
    logic               o_mem_write;
    logic               o_branch;
    logic               o_jump;
    logic               o_alu_src;
    logic               o_illegal;

    modport master (
        output i_instruction, i_pc, i_flush, i_ex_mem_read, i_ex_rd,
        input  o_hazard_detected, o_valid, o_pc, o_rs1, o_rs2, o_rd,
        input  o_funct3, o_funct7b5, o_imm, o_reg_write, o_mem_read,
        input  o_mem_write, o_branch, o_jump, o_alu_src, o_illegal
    );

    modport slave (
        input  i_instruction, i_pc, i_flush, i_ex_mem_read, i_ex_rd,
        output o_hazard_detected, o_valid, o_pc, o_rs1, o_rs2, o_rd,
        output o_funct3, o_funct7b5, o_imm, o_reg_write, o_mem_read,
        output o_mem_write, o_branch, o_jump, o_alu_src, o_illegal
    );
endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator; instr[6:0] is not needed so it is not taken.
module imm_gen
    import riscv_defs::*;
(
    input  logic [31:7] i_instr,
    input  imm_type_t   i_type,
    output logic [31:0] o_imm
);
    always_comb begin
        o_imm = '0;
        unique case (i_type)
            IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25],
                            i_instr[11:7]};
            IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: o_imm = {i_instr[31:12], 12'b0};
            IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31],
                            i_instr[19:12], i_instr[20],
                            i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end
endmodule

// File: rtl/idecode.sv
// Decode stage: IF/ID register, RV32I control decode, load-use detect.
module idecode
    import riscv_defs::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_REG  = 5
) (
    input  logic  i_clock,
    input  logic  i_reset,
    idecode_if.slave bus
);
    logic [NB_WORD-1:0] ir_q, ir_d;
    logic [NB_ADDR-1:0] pc_q, pc_d;
    logic               valid_q, valid_d;

    logic [6:0]        opcode;
    logic [NB_REG-1:0] rs1, rs2, rd;
    imm_type_t         imm_type;
    logic uses_rs1, uses_rs2, illegal_op;
    logic reg_write, mem_read, mem_write, branch, jump, alu_src;
    logic hazard, live;

    assign opcode = ir_q[6:0];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign rd     = ir_q[11:7];

    always_comb begin
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        illegal_op = 1'b0;
        imm_type   = IMM_NONE;
        unique case (opcode)
            OPC_OP: begin
                reg_write = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_OP_IMM: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                uses_rs1  = 1'b1;
                imm_type  = IMM_I;
            end
            OPC_LOAD: begin
                reg_write = 1'b1;
                mem_read  = 1'b1;
                alu_src   = 1'b1;
                uses_rs1  = 1'b1;
                imm_type  = IMM_I;
            end
            OPC_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                imm_type  = IMM_S;
            end
            OPC_BRANCH: begin
                branch   = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_type = IMM_B;
            end
            OPC_JAL: begin
                jump      = 1'b1;
                reg_write = 1'b1;
                imm_type  = IMM_J;
            end
            OPC_JALR: begin
                jump      = 1'b1;
                reg_write = 1'b1;
                alu_src   = 1'b1;
                uses_rs1  = 1'b1;
                imm_type  = IMM_I;
            end
            OPC_LUI, OPC_AUIPC: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_type  = IMM_U;
            end
            default: illegal_op = 1'b1;
        endcase
    end

    // Flush masks the stall: fetch ignores the branch while frozen.
    assign hazard = valid_q & bus.i_ex_mem_read
                  & (bus.i_ex_rd != '0)
                  & ((uses_rs1 & (rs1 == bus.i_ex_rd))
                   | (uses_rs2 & (rs2 == bus.i_ex_rd)))
                  & ~bus.i_flush;

    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (bus.i_flush) begin
            ir_d    = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!hazard) begin
            ir_d    = bus.i_instruction;
            pc_d    = bus.i_pc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            ir_q    <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    imm_gen u_imm_gen (
        .i_instr (ir_q[31:7]),
        .i_type  (imm_type),
        .o_imm   (bus.o_imm)
    );

    assign live = valid_q & ~hazard;

    assign bus.o_hazard_detected = hazard;
    assign bus.o_valid     = live;
    assign bus.o_pc        = pc_q;
    assign bus.o_rs1       = rs1;
    assign bus.o_rs2       = rs2;
    assign bus.o_rd        = rd;
    assign bus.o_funct3    = ir_q[14:12];
    assign bus.o_funct7b5  = ir_q[30];
    assign bus.o_reg_write = live & reg_write;
    assign bus.o_mem_read  = live & mem_read;
    assign bus.o_mem_write = live & mem_write;
    assign bus.o_branch    = live & branch;
    assign bus.o_jump      = live & jump;
    assign bus.o_alu_src   = live & alu_src;
    assign bus.o_illegal   = valid_q & illegal_op;
endmodule

// File: tb/tb_idecode.sv
// Directed self-checking bench for the idecode stage.
module tb_idecode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idecode_if bus ();

    idecode u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    localparam logic [31:0] LW    = 32'h0000A283;
    localparam logic [31:0] ADD   = 32'h00228333;
    localparam logic [31:0] ADDX0 = 32'h00200333;
    localparam logic [31:0] ADDI  = 32'h00100393;
    localparam logic [31:0] BEQ   = 32'hFE000EE3;
    localparam logic [31:0] JAL   = 32'h001000EF;
    localparam logic [31:0] SW    = 32'hFE20AC23;
    localparam logic [31:0] LUI   = 32'h123451B7;
    localparam logic [31:0] ILL   = 32'h0000007F;

    function automatic logic [5:0] ctl();
        return {bus.o_reg_write, bus.o_mem_read, bus.o_mem_write,
                bus.o_branch, bus.o_jump, bus.o_alu_src};
    endfunction

    task automatic load(input logic [31:0] ins, input logic [31:0] pc);
        bus.i_instruction = ins;
        bus.i_pc = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        load(ADD, 32'h100);
        checks++;
        if (bus.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got %b exp 1", bus.o_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_valid, bus.o_hazard_detected, bus.o_illegal} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_flags got %b exp 000",
                     {bus.o_valid, bus.o_hazard_detected, bus.o_illegal});
        end
        checks++;
        if (ctl() !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_ctl got %b exp 000000", ctl());
        end
        checks++;
        if (bus.o_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_pc got %h exp 0", bus.o_pc);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        bus.i_ex_mem_read = 1'b0;
        bus.i_ex_rd = 5'd0;
        load(LW, 32'h200);
        checks++;
        if ({bus.o_valid, ctl(), bus.o_rd, bus.o_rs1} !== {1'b1, 6'b110001, 5'd5, 5'd1}) begin
            errors++;
            $display("FAIL lw_decode got %b/%b rd=%0d rs1=%0d exp 1/110001 rd=5 rs1=1",
                     bus.o_valid, ctl(), bus.o_rd, bus.o_rs1);
        end
        checks++;
        if ({bus.o_funct3, bus.o_imm} !== {3'd2, 32'h0}) begin
            errors++;
            $display("FAIL lw_fields got f3=%0d imm=%h exp f3=2 imm=0",
                     bus.o_funct3, bus.o_imm);
        end
        load(ADD, 32'h204);
        bus.i_ex_mem_read = 1'b1;
        bus.i_ex_rd = 5'd5;
        bus.i_instruction = ADDI;
        bus.i_pc = 32'h208;
        #1;
        checks++;
        if ({bus.o_hazard_detected, bus.o_valid, ctl()} !== {2'b10, 6'b0}) begin
            errors++;
            $display("FAIL load_use_stall got %b exp 10000000",
                     {bus.o_hazard_detected, bus.o_valid, ctl()});
        end
        @(posedge clk);
        #1;
        bus.i_ex_mem_read = 1'b0;
        #1;
        checks++;
        if ({bus.o_hazard_detected, bus.o_valid, bus.o_rd, bus.o_pc}
            !== {2'b01, 5'd6, 32'h204}) begin
            errors++;
            $display("FAIL load_use_held got hz=%b v=%b rd=%0d pc=%h exp 0 1 6 204",
                     bus.o_hazard_detected, bus.o_valid, bus.o_rd, bus.o_pc);
        end
        checks++;
        if (ctl() !== 6'b100000) begin
            errors++;
            $display("FAIL load_use_release_ctl got %b exp 100000", ctl());
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.o_rd, bus.o_imm, bus.o_pc} !== {5'd7, 32'h1, 32'h208}) begin
            errors++;
            $display("FAIL after_stall got rd=%0d imm=%h pc=%h exp 7 1 208",
                     bus.o_rd, bus.o_imm, bus.o_pc);
        end
    endtask

    task automatic test_x0();
        load(ADDX0, 32'h300);
        bus.i_ex_mem_read = 1'b1;
        bus.i_ex_rd = 5'd0;
        #1;
        checks++;
        if ({bus.o_hazard_detected, bus.o_valid} !== 2'b01) begin
            errors++;
            $display("FAIL x0_no_hazard got %b exp 01",
                     {bus.o_hazard_detected, bus.o_valid});
        end
        bus.i_ex_rd = 5'd2;
        #1;
        checks++;
        if (bus.o_hazard_detected !== 1'b1) begin
            errors++;
            $display("FAIL rs2_hazard got %b exp 1", bus.o_hazard_detected);
        end
        bus.i_ex_mem_read = 1'b0;
        load(ADDI, 32'h304);
        bus.i_ex_mem_read = 1'b1;
        bus.i_ex_rd = 5'd1;
        #1;
        checks++;
        if (bus.o_hazard_detected !== 1'b0) begin
            errors++;
            $display("FAIL itype_rs2_ignored got %b exp 0", bus.o_hazard_detected);
        end
        bus.i_ex_mem_read = 1'b0;
    endtask

    task automatic test_flush();
        load(ADD, 32'h400);
        bus.i_ex_mem_read = 1'b1;
        bus.i_ex_rd = 5'd5;
        bus.i_flush = 1'b1;
        bus.i_instruction = LUI;
        #1;
        checks++;
        if (bus.o_hazard_detected !== 1'b0) begin
            errors++;
            $display("FAIL flush_masks_hazard got %b exp 0", bus.o_hazard_detected);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.o_valid, ctl(), bus.o_illegal} !== 8'b0) begin
            errors++;
            $display("FAIL flush_bubble got %b exp 00000000",
                     {bus.o_valid, ctl(), bus.o_illegal});
        end
        bus.i_flush = 1'b0;
        bus.i_ex_mem_read = 1'b0;
    endtask

    task automatic test_imm();
        load(BEQ, 32'h500);
        checks++;
        if ({bus.o_imm, ctl(), bus.o_funct7b5} !== {32'hFFFF_FFFC, 6'b000100, 1'b1}) begin
            errors++;
            $display("FAIL beq_imm got %h/%b/%b exp fffffffc/000100/1",
                     bus.o_imm, ctl(), bus.o_funct7b5);
        end
        load(JAL, 32'h504);
        checks++;
        if ({bus.o_imm, ctl(), bus.o_rd} !== {32'h0000_0800, 6'b100010, 5'd1}) begin
            errors++;
            $display("FAIL jal_imm got %h/%b rd=%0d exp 00000800/100010 rd=1",
                     bus.o_imm, ctl(), bus.o_rd);
        end
        load(SW, 32'h508);
        checks++;
        if ({bus.o_imm, ctl(), bus.o_funct3} !== {32'hFFFF_FFF8, 6'b001001, 3'd2}) begin
            errors++;
            $display("FAIL sw_imm got %h/%b f3=%0d exp fffffff8/001001 f3=2",
                     bus.o_imm, ctl(), bus.o_funct3);
        end
        load(LUI, 32'h50C);
        checks++;
        if ({bus.o_imm, ctl(), bus.o_rd} !== {32'h1234_5000, 6'b100001, 5'd3}) begin
            errors++;
            $display("FAIL lui_imm got %h/%b rd=%0d exp 12345000/100001 rd=3",
                     bus.o_imm, ctl(), bus.o_rd);
        end
    endtask

    task automatic test_illegal();
        load(ILL, 32'h600);
        checks++;
        if ({bus.o_illegal, bus.o_valid, ctl(), bus.o_imm} !== {2'b11, 6'b0, 32'h0}) begin
            errors++;
            $display("FAIL illegal got ill=%b v=%b ctl=%b imm=%h exp 1 1 000000 0",
                     bus.o_illegal, bus.o_valid, ctl(), bus.o_imm);
        end
    endtask

    initial begin
        bus.i_instruction = 32'h0000_0013;
        bus.i_pc = '0;
        bus.i_flush = 1'b0;
        bus.i_ex_mem_read = 1'b0;
        bus.i_ex_rd = '0;
        #1;
        checks++;
        if ({bus.o_valid, bus.o_hazard_detected, bus.o_illegal, ctl()} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state got %b exp 000000000",
                     {bus.o_valid, bus.o_hazard_detected, bus.o_illegal, ctl()});
        end
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_x0();
        test_flush();
        test_imm();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
